// File: rtl/riscv_bif_arbiter_pkg.sv
// riscv_bif_arbiter_pkg: shared encodings and types for the bus interface arbiter.
//   ARB_IDLE/ARB_REQ/ARB_RESP : 2-bit arbiter FSM state encodings
//   ARB_OWN_INST/ARB_OWN_DATA : 1-bit bus owner encodings
//   bus_cmd_t                 : one bus command (address + write attributes)
//   cnt_width()               : width of the starvation counter for a given limit
package riscv_bif_arbiter_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MASK_W      = 4;
  localparam int unsigned ARB_STATE_W = 2;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic ARB_OWN_INST = 1'b0;
  localparam logic ARB_OWN_DATA = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              rnw;
    logic [MASK_W-1:0] wmask;
    logic [XLEN-1:0]   wdata;
  } bus_cmd_t;

  // Counter must hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/riscv_bif_arbiter_if.sv
// riscv_bif_arbiter_if: requester ports (fetch, MEM-stage data) and the shared
// memory bus, bundled for the arbiter.
//   slave  : arbiter side (takes reqs/bus responses, drives acks and bus command)
//   master : environment side (fetch/MEM stages and memory)
interface riscv_bif_arbiter_if;
  import riscv_bif_arbiter_pkg::*;

  logic              inst_req;
  logic [XLEN-1:0]   inst_addr;
  logic              inst_ack;
  logic [XLEN-1:0]   inst_rdata;

  logic              data_req;
  logic [XLEN-1:0]   data_addr;
  logic              data_rnw;
  logic [MASK_W-1:0] data_wmask;
  logic [XLEN-1:0]   data_wdata;
  logic              data_ack;
  logic [XLEN-1:0]   data_rdata;

  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_rnw;
  logic [MASK_W-1:0] mem_wmask;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_addr, data_rnw, data_wmask, data_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output inst_ack, inst_rdata, data_ack, data_rdata,
    output mem_req, mem_addr, mem_rnw, mem_wmask, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_addr, data_rnw, data_wmask, data_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  inst_ack, inst_rdata, data_ack, data_rdata,
    input  mem_req, mem_addr, mem_rnw, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/riscv_bif_arb_sel.sv
// riscv_bif_arb_sel: grant decision between fetch and data requesters, plus the
// policy state it needs.
//   Default build  : fixed priority (data first) with a starvation counter that
//                    forces an inst grant after STARVE_MAX data grants while
//                    inst_req waits.
//   RISCV_BIF_ARB_RR_EN defined : round-robin on the last granted owner; the
//                    starvation counter is not built.
// Ports:
//   clk, rstn          clock, async active-low reset
//   inst_req, data_req request lines
//   grant_en           a grant is taken this cycle; update policy state
//   grant_c            at least one requester is asking
//   owner_c            owner that wins if a grant is taken now
module riscv_bif_arb_sel
  import riscv_bif_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_c,
  output logic owner_c
);

  assign grant_c = inst_req | data_req;

`ifdef RISCV_BIF_ARB_RR_EN

  logic last_q;

  // On contention the requester that did not own the last grant wins.
  always_comb begin
    owner_c = ARB_OWN_INST;
    if (inst_req && data_req) begin
      owner_c = (last_q == ARB_OWN_INST) ? ARB_OWN_DATA : ARB_OWN_INST;
    end else if (data_req) begin
      owner_c = ARB_OWN_DATA;
    end
  end

  // Reset treats inst as last owner so data wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= ARB_OWN_INST;
    end else if (grant_en) begin
      last_q <= owner_c;
    end
  end

`else

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             starved;

  assign starved = (cnt_q == CNT_MAX);

  // Data first, except when fetch has waited through CNT_MAX data grants.
  always_comb begin
    owner_c = ARB_OWN_INST;
    if (data_req && !(inst_req && starved)) begin
      owner_c = ARB_OWN_DATA;
    end
  end

  // Count data grants taken over a waiting fetch; any inst grant clears.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_en) begin
      if (owner_c == ARB_OWN_INST) begin
        cnt_d = '0;
      end else if (inst_req && !starved) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`endif

endmodule

// File: rtl/riscv_bif_arbiter.sv
// riscv_bif_arbiter: shares one memory bus between instruction fetch and the
// MEM-stage data port, one transaction outstanding at a time.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   riscv_bif_arbiter_if.slave: inst_* / data_* req-ack ports and mem_* bus
// Parameters:
//   STARVE_MAX  data grants allowed over a waiting fetch (1..15, fixed mode only)
// Build option:
//   RISCV_BIF_ARB_RR_EN  round-robin arbitration instead of fixed priority
// FSM: IDLE -> REQ (mem_req high until mem_ack) -> RESP (wait mem_rvalid) -> IDLE.
// Writes finish on mem_ack and skip RESP. Acks and rdata are combinational
// from mem_ack/mem_rvalid; mem_req is registered.
module riscv_bif_arbiter
  import riscv_bif_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rstn,
  riscv_bif_arbiter_if.slave bus
);

  logic [ARB_STATE_W-1:0] state_q;
  logic [ARB_STATE_W-1:0] state_d;
  logic                   owner_q;
  logic                   owner_d;
  logic                   mem_req_q;
  logic                   mem_req_d;
  logic                   grant_en;
  logic                   grant_c;
  logic                   sel_owner_c;

  bus_cmd_t inst_cmd;
  bus_cmd_t data_cmd;
  bus_cmd_t mem_cmd;

  logic req_done_c;
  logic resp_done_c;
  logic inst_ack_c;
  logic data_ack_c;
  logic data_rd_ack_c;

  riscv_bif_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk      (clk),
    .rstn     (rstn),
    .inst_req (bus.inst_req),
    .data_req (bus.data_req),
    .grant_en (grant_en),
    .grant_c  (grant_c),
    .owner_c  (sel_owner_c)
  );

  // State, owner and bus request registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_OWN_INST;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_en = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_c) begin
          grant_en = 1'b1;
          owner_d  = sel_owner_c;
          state_d  = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.mem_ack) begin
          if (owner_q == ARB_OWN_DATA && !bus.data_rnw) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (bus.mem_rvalid) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    mem_req_d = (state_d == ARB_REQ);
  end

  // Owner commands; fetch is always a full-word read.
  always_comb begin
    inst_cmd       = '0;
    inst_cmd.addr  = bus.inst_addr;
    inst_cmd.rnw   = 1'b1;
    data_cmd       = '0;
    data_cmd.addr  = bus.data_addr;
    data_cmd.rnw   = bus.data_rnw;
    data_cmd.wmask = bus.data_wmask;
    data_cmd.wdata = bus.data_wdata;
  end

  // Bus attributes follow the owner's held inputs only while requesting.
  always_comb begin
    mem_cmd = '0;
    if (state_q == ARB_REQ) begin
      mem_cmd = (owner_q == ARB_OWN_DATA) ? data_cmd : inst_cmd;
    end
  end

  assign req_done_c    = (state_q == ARB_REQ)  && bus.mem_ack;
  assign resp_done_c   = (state_q == ARB_RESP) && bus.mem_rvalid;
  assign inst_ack_c    = (owner_q == ARB_OWN_INST) && resp_done_c;
  assign data_rd_ack_c = (owner_q == ARB_OWN_DATA) && resp_done_c;
  assign data_ack_c    = data_rd_ack_c ||
                         ((owner_q == ARB_OWN_DATA) && req_done_c && !bus.data_rnw);

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_cmd.addr;
  assign bus.mem_rnw    = mem_cmd.rnw;
  assign bus.mem_wmask  = mem_cmd.wmask;
  assign bus.mem_wdata  = mem_cmd.wdata;

  // Read data passes through only on the owner's read ack, else 0.
  assign bus.inst_ack   = inst_ack_c;
  assign bus.inst_rdata = inst_ack_c ? bus.mem_rdata : '0;
  assign bus.data_ack   = data_ack_c;
  assign bus.data_rdata = data_rd_ack_c ? bus.mem_rdata : '0;

endmodule
